// File: rtl/alu_multibyte_seq.sv
// Byte-serial sequencer for an external 8-bit ALU: walks a multi-byte operand
// through the register file one byte per cycle, chaining SC_OUT into SC_IN.
module alu_multibyte_seq #(
  parameter int         NBYTES = 2,
  parameter int         AW     = 4,
  parameter logic [2:0] OP_ADD = 3'd0,
  parameter logic [2:0] OP_RSH = 3'd1,
  parameter logic [2:0] OP_XOR = 3'd2,
  parameter logic [2:0] OP_AND = 3'd3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   op,
  input  logic [$clog2(NBYTES+1)-1:0]  len,
  input  logic                         cin,
  input  logic [AW-1:0]                ra_base,
  input  logic [AW-1:0]                rb_base,
  input  logic [AW-1:0]                rd_base,
  output logic [AW-1:0]                rf_addr_a,
  output logic [AW-1:0]                rf_addr_b,
  input  logic [7:0]                   rf_data_a,
  input  logic [7:0]                   rf_data_b,
  output logic                         rf_wr_en,
  output logic [AW-1:0]                rf_wr_addr,
  output logic [7:0]                   rf_wr_data,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic [2:0]                   alu_op,
  output logic                         alu_sc_in,
  input  logic [7:0]                   alu_out,
  input  logic                         alu_sc_out,
  output logic                         busy,
  output logic                         done,
  output logic                         carry_flag,
  output logic                         zero_flag
);

  localparam int              LW  = $clog2(NBYTES + 1);
  localparam logic [LW-1:0]   ONE = LW'(1);
  localparam logic [LW-1:0]   NB  = LW'(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [2:0]     op_q;
  logic           cin_q;
  logic [AW-1:0]  ra_q;
  logic [AW-1:0]  rb_q;
  logic [AW-1:0]  rd_q;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  k_q;
  logic           sc_q;
  logic           zacc_q;

  logic           accept;
  logic           first;
  logic           last;
  logic           is_rsh;
  logic           no_chain;
  logic [LW-1:0]  eff_len;
  logic [LW-1:0]  b;
  logic [AW-1:0]  b_addr;
  logic           byte_zero;
  logic           zero_so_far;

  // Byte index and chaining are derived from the latched request, so the
  // request inputs may change freely once the sequence has started.
  always_comb begin
    eff_len     = (len > NB) ? NB : len;
    first       = (k_q == '0);
    last        = (k_q == (len_q - ONE));
    is_rsh      = (op_q == OP_RSH);
    no_chain    = (op_q == OP_XOR) || (op_q == OP_AND);
    b           = is_rsh ? (len_q - ONE - k_q) : k_q;
    b_addr      = AW'(b);
    byte_zero   = (alu_out == 8'h00);
    zero_so_far = first ? byte_zero : (zacc_q & byte_zero);
  end

  always_comb begin
    rf_addr_a  = ra_q + b_addr;
    rf_addr_b  = rb_q + b_addr;
    rf_wr_addr = rd_q + b_addr;
    rf_wr_data = alu_out;
    alu_a      = rf_data_a;
    alu_b      = rf_data_b;
    alu_op     = op_q;
    alu_sc_in  = no_chain ? 1'b0 : (first ? cin_q : sc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    rf_wr_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        rf_wr_en = !reset;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Request latch, byte counter, carry chain and flag accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      cin_q      <= 1'b0;
      ra_q       <= '0;
      rb_q       <= '0;
      rd_q       <= '0;
      len_q      <= '0;
      k_q        <= '0;
      sc_q       <= 1'b0;
      zacc_q     <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (accept) begin
      op_q  <= op;
      cin_q <= cin;
      ra_q  <= ra_base;
      rb_q  <= rb_base;
      rd_q  <= rd_base;
      len_q <= eff_len;
      k_q   <= '0;
    end else if (state == S_RUN) begin
      sc_q   <= alu_sc_out;
      zacc_q <= zero_so_far;
      if (last) begin
        k_q        <= '0;
        carry_flag <= alu_sc_out;
        zero_flag  <= zero_so_far;
      end else begin
        k_q <= k_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Self-checking bench: register file and ALU models around the sequencer,
// with directed corner cases followed by random operations.
module tb_alu_multibyte_seq;

  localparam int         NBYTES = 2;
  localparam int         AW     = 4;
  localparam int         LW     = $clog2(NBYTES + 1);
  localparam int         NREGS  = 1 << AW;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_RSH = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_BAD = 3'd7;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2:0]     op;
  logic [LW-1:0]  len;
  logic           cin;
  logic [AW-1:0]  ra_base;
  logic [AW-1:0]  rb_base;
  logic [AW-1:0]  rd_base;
  logic [AW-1:0]  rf_addr_a;
  logic [AW-1:0]  rf_addr_b;
  logic [7:0]     rf_data_a;
  logic [7:0]     rf_data_b;
  logic           rf_wr_en;
  logic [AW-1:0]  rf_wr_addr;
  logic [7:0]     rf_wr_data;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [2:0]     alu_op;
  logic           alu_sc_in;
  logic [7:0]     alu_out;
  logic           alu_sc_out;
  logic           busy;
  logic           done;
  logic           carry_flag;
  logic           zero_flag;

  logic [7:0]     mem [NREGS];
  logic           ld_en;
  logic [AW-1:0]  ld_addr;
  logic [7:0]     ld_data;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  int done_count  = 0;

  alu_multibyte_seq #(
    .NBYTES (NBYTES),
    .AW     (AW),
    .OP_ADD (OP_ADD),
    .OP_RSH (OP_RSH),
    .OP_XOR (OP_XOR),
    .OP_AND (OP_AND)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .len        (len),
    .cin        (cin),
    .ra_base    (ra_base),
    .rb_base    (rb_base),
    .rd_base    (rd_base),
    .rf_addr_a  (rf_addr_a),
    .rf_addr_b  (rf_addr_b),
    .rf_data_a  (rf_data_a),
    .rf_data_b  (rf_data_b),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_sc_in  (alu_sc_in),
    .alu_out    (alu_out),
    .alu_sc_out (alu_sc_out),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  assign rf_data_a = mem[rf_addr_a];
  assign rf_data_b = mem[rf_addr_b];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (rf_wr_en) begin
      mem[rf_wr_addr] <= rf_wr_data;
      wr_count++;
    end
    if (done) done_count++;
  end

  // Model of the downstream 8-bit ALU.
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    case (alu_op)
      OP_ADD: {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc_in};
      OP_RSH: begin
        alu_out    = {alu_sc_in, alu_a[7:1]};
        alu_sc_out = alu_a[0];
      end
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_AND: alu_out = alu_a & alu_b;
      default: ;
    endcase
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic loadByte(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [LW-1:0] l, input logic c,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input logic [AW-1:0] rd);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    len     = l;
    cin     = c;
    ra_base = ra;
    rb_base = rb;
    rd_base = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] readWord(input logic [AW-1:0] base, input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = mem[AW'(base + AW'(i))];
    return w;
  endfunction

  // Runs one full operation and checks every RUN cycle, the DONE cycle and the
  // resulting register-file contents against whole-word arithmetic.
  task automatic runOp(input logic [2:0] o, input int lreq, input logic c,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic [AW-1:0] rd, input bit holdStart);
    int          n;
    int          bi;
    int          wc0;
    int          dc0;
    logic [63:0] a;
    logic [63:0] bw;
    logic [63:0] mask;
    logic [63:0] full;
    logic [63:0] expRes;
    logic        expCarry;
    logic        expSc;
    n    = (lreq > NBYTES) ? NBYTES : lreq;
    a    = readWord(ra, n);
    bw   = readWord(rb, n);
    mask = (64'd1 << (8 * n)) - 64'd1;
    expCarry = 1'b0;
    case (o)
      OP_ADD: begin
        full     = a + bw + {63'd0, c};
        expRes   = full & mask;
        expCarry = full[8 * n];
      end
      OP_RSH: begin
        expRes   = ((a >> 1) | ({63'd0, c} << (8 * n - 1))) & mask;
        expCarry = a[0];
      end
      OP_XOR:  expRes = a ^ bw;
      OP_AND:  expRes = a & bw;
      default: expRes = '0;
    endcase
    wc0 = wr_count;
    dc0 = done_count;
    applyStimulus(o, LW'(lreq), c, ra, rb, rd);
    if (holdStart) len = LW'(1);
    else start = 1'b0;
    for (int k = 0; k < n; k++) begin
      bi = (o == OP_RSH) ? (n - 1 - k) : k;
      checkOutput("run_busy", {31'd0, busy}, 32'd1);
      checkOutput("run_done", {31'd0, done}, 32'd0);
      checkOutput("run_wr_en", {31'd0, rf_wr_en}, 32'd1);
      checkOutput("run_wr_addr", {28'd0, rf_wr_addr}, {28'd0, AW'(rd + AW'(bi))});
      if (o == OP_XOR || o == OP_AND) expSc = 1'b0;
      else if (k == 0) expSc = c;
      else if (o == OP_ADD) begin
        full  = (a & ((64'd1 << (8 * bi)) - 64'd1)) + (bw & ((64'd1 << (8 * bi)) - 64'd1)) + {63'd0, c};
        expSc = full[8 * bi];
      end else expSc = a[8 * (bi + 1)];
      if (o != OP_BAD) checkOutput("run_sc_in", {31'd0, alu_sc_in}, {31'd0, expSc});
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("done_busy", {31'd0, busy}, 32'd1);
    checkOutput("done_wr_en", {31'd0, rf_wr_en}, 32'd0);
    checkOutput("carry_flag", {31'd0, carry_flag}, {31'd0, expCarry});
    checkOutput("zero_flag", {31'd0, zero_flag}, {31'd0, (expRes == 64'd0)});
    @(posedge clk);
    #1;
    checkOutput("idle_done", {31'd0, done}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("result", readWord(rd, n), expRes);
    checkOutput("write_count", wr_count - wc0, n);
    checkOutput("done_count", done_count - dc0, 32'd1);
  endtask

  function automatic bit safeBase(input logic [AW-1:0] x, input logic [AW-1:0] rd, input int n);
    if (x == rd) return 1'b1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (AW'(x + AW'(i)) == AW'(rd + AW'(j))) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int            wc0;
    int            dc0;
    int            lreq;
    logic [2:0]    o;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rd;
    logic [2:0]    opTable [5];
    opTable = '{OP_ADD, OP_RSH, OP_XOR, OP_AND, OP_BAD};

    reset   = 1'b1;
    start   = 1'b0;
    op      = '0;
    len     = '0;
    cin     = 1'b0;
    ra_base = '0;
    rb_base = '0;
    rd_base = '0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_wr_en", {31'd0, rf_wr_en}, 32'd0);
    checkOutput("reset_carry", {31'd0, carry_flag}, 32'd0);
    checkOutput("reset_zero", {31'd0, zero_flag}, 32'd0);
    reset = 1'b0;

    loadByte(4'h0, 8'hFF); loadByte(4'h1, 8'h00);
    loadByte(4'h2, 8'h01); loadByte(4'h3, 8'h00);
    runOp(OP_ADD, 2, 1'b0, 4'h0, 4'h2, 4'h8, 1'b0);
    checkOutput("add_byte0", {24'd0, mem[8]}, 32'h00);
    checkOutput("add_byte1", {24'd0, mem[9]}, 32'h01);

    loadByte(4'h1, 8'hFF);
    runOp(OP_ADD, 2, 1'b0, 4'h0, 4'h2, 4'h8, 1'b0);

    loadByte(4'h4, 8'h03); loadByte(4'h5, 8'h01);
    runOp(OP_RSH, 2, 1'b1, 4'h4, 4'h2, 4'hA, 1'b0);
    checkOutput("rsh_byte0", {24'd0, mem[10]}, 32'h81);
    checkOutput("rsh_byte1", {24'd0, mem[11]}, 32'h80);

    loadByte(4'h6, 8'h5A); loadByte(4'h7, 8'h5A);
    runOp(OP_XOR, 1, 1'b1, 4'h6, 4'h7, 4'hC, 1'b0);

    loadByte(4'hF, 8'h34); loadByte(4'h0, 8'h12);
    loadByte(4'h5, 8'h11); loadByte(4'h6, 8'h22);
    runOp(OP_ADD, 2, 1'b1, 4'hF, 4'h5, 4'hF, 1'b0);

    runOp(OP_AND, 3, 1'b0, 4'h2, 4'h4, 4'h9, 1'b1);

    wc0 = wr_count;
    dc0 = done_count;
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("len0_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    checkOutput("len0_writes", wr_count - wc0, 32'd0);
    checkOutput("len0_dones", done_count - dc0, 32'd0);

    loadByte(4'h0, 8'hFF); loadByte(4'h1, 8'hFF);
    loadByte(4'h2, 8'h01); loadByte(4'h3, 8'h00);
    runOp(OP_ADD, 2, 1'b0, 4'h0, 4'h2, 4'h8, 1'b0);
    loadByte(4'hD, 8'hA5);
    wc0 = wr_count;
    dc0 = done_count;
    applyStimulus(OP_ADD, LW'(2), 1'b1, 4'h0, 4'h2, 4'hD);
    start = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_run_wr_en", {31'd0, rf_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_run_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_run_carry", {31'd0, carry_flag}, 32'd0);
    checkOutput("rst_run_zero", {31'd0, zero_flag}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_run_writes", wr_count - wc0, 32'd0);
    checkOutput("rst_run_dones", done_count - dc0, 32'd0);
    checkOutput("rst_run_mem", {24'd0, mem[13]}, 32'hA5);

    for (int t = 0; t < 40; t++) begin
      o    = opTable[$urandom_range(0, 4)];
      lreq = $urandom_range(1, 3);
      do begin
        ra = AW'($urandom);
        rb = AW'($urandom);
        rd = AW'($urandom);
      end while (!safeBase(ra, rd, NBYTES) || !safeBase(rb, rd, NBYTES));
      for (int i = 0; i < NBYTES; i++) loadByte(AW'(ra + AW'(i)), 8'($urandom));
      for (int i = 0; i < NBYTES; i++) loadByte(AW'(rb + AW'(i)), 8'($urandom));
      runOp(o, lreq, 1'($urandom), ra, rb, rd, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
